// File: rtl/ext_pipe_unit.sv
// rtl/ext_pipe_unit.sv - immediate/load-data extender feeding a DEPTH-entry output FIFO
// Define EXT_PIPE_ALIGN_CHECK_EN to flag misaligned loads and undefined modes on out_exc.
module ext_pipe_unit #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int DEPTH  = 2,
   parameter int TAG_W  = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [3:0]                    mode,
   input  logic [IMM_W-1:0]              src_imm,
   input  logic [DATA_W-7:0]             src_idx,
   input  logic [DATA_W-1:0]             src_pc,
   input  logic [DATA_W-1:0]             src_word,
   input  logic [$clog2(DATA_W/8)-1:0]   src_off,
   input  logic [TAG_W-1:0]              src_tag,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_res,
   output logic [TAG_W-1:0]              out_tag,
   output logic                          out_exc
);

   localparam int OFF_W = $clog2(DATA_W/8);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] simm;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [DATA_W-1:0] res_c;
   logic              unused_pc;

   assign simm      = {{(DATA_W-IMM_W){src_imm[IMM_W-1]}}, src_imm};
   assign byte_v    = src_word[{src_off, 3'b000} +: 8];
   // Half lanes are naturally aligned: the low offset bit does not move the lane.
   assign half_v    = src_word[{src_off[OFF_W-1:1], 4'b0000} +: 16];
   assign unused_pc = ^src_pc[DATA_W-5:0];

   always_comb begin
      res_c = '0;
      case (mode)
         4'd0:    res_c = {{(DATA_W-IMM_W){1'b0}}, src_imm};
         4'd1:    res_c = simm;
         4'd2:    res_c = {src_imm, {(DATA_W-IMM_W){1'b0}}};
         4'd3:    res_c = simm << 2;
         4'd4:    res_c = {src_pc[DATA_W-1:DATA_W-4], src_idx, 2'b00};
         4'd5:    res_c = {{(DATA_W-8){byte_v[7]}}, byte_v};
         4'd6:    res_c = {{(DATA_W-8){1'b0}}, byte_v};
         4'd7:    res_c = {{(DATA_W-16){half_v[15]}}, half_v};
         4'd8:    res_c = {{(DATA_W-16){1'b0}}, half_v};
         4'd9:    res_c = src_word;
         default: res_c = '0;
      endcase
   end

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push_en, pop_en;
   logic [DATA_W-1:0] res_mem [DEPTH];
   logic [TAG_W-1:0]  tag_mem [DEPTH];

   assign in_ready  = (count < CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push_en   = in_valid && in_ready && !flush && !reset;
   assign pop_en    = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (push_en) begin
         res_mem[wr_ptr] <= res_c;
         tag_mem[wr_ptr] <= src_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_en)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Empty FIFO drives zeros so the head never exposes stale entries.
   assign out_res = out_valid ? res_mem[rd_ptr] : '0;
   assign out_tag = out_valid ? tag_mem[rd_ptr] : '0;

`ifdef EXT_PIPE_ALIGN_CHECK_EN
   logic exc_c;
   logic exc_mem [DEPTH];

   always_comb begin
      exc_c = 1'b0;
      case (mode)
         4'd7, 4'd8:   exc_c = src_off[0];
         4'd9:         exc_c = (src_off != '0);
         4'd10, 4'd11, 4'd12,
         4'd13, 4'd14, 4'd15: exc_c = 1'b1;
         default:      exc_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_en)
         exc_mem[wr_ptr] <= exc_c;
   end

   assign out_exc = out_valid ? exc_mem[rd_ptr] : 1'b0;
`else
   assign out_exc = 1'b0;
`endif

endmodule
